// File: rtl/uart_pkg.sv
// Shared definitions for the UART Rx frame parser: default start-of-frame marker,
// parser phase and FIFO fetch encodings, error codes and a small 8-bit add helper.
package uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  // Frame phase, advanced once per captured byte.
  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CKS
  } phase_e;

  // FIFO-side handshake state.
  typedef enum logic [1:0] {
    FETCH,
    CAPTURE,
    HOLD
  } fetch_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CKS  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Modulo-256 add used for the running checksum.
  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_fifo_fetch.sv
// FIFO-side pop handshake for the UART Rx frame parser.
// While req is high and the FIFO is not empty, pulses fifo_rd for one cycle, then presents
// the FIFO read data on byte_data with a one-cycle byte_vld in the following cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req               consumer wants another byte
//   fifo_empty        Rx FIFO empty flag
//   fifo_rd           Rx FIFO pop strobe (never asserted while fifo_empty)
//   fifo_data         Rx FIFO read data, valid the cycle after fifo_rd
//   byte_data         captured byte, qualified by byte_vld
//   byte_vld          one-cycle pulse per popped byte
module uart_fifo_fetch
  import uart_pkg::*;
#(
  parameter int unsigned dbit = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            fifo_empty,
  output logic            fifo_rd,
  input  logic [dbit-1:0] fifo_data,
  output logic [dbit-1:0] byte_data,
  output logic            byte_vld
);

  fetch_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // HOLD is the reset/idle state, so fifo_rd stays low while reset is released even if
  // the FIFO already holds data.
  always_comb begin
    state_d  = state_q;
    fifo_rd  = 1'b0;
    byte_vld = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (req) state_d = FETCH;
      end
      FETCH: begin
        if (!req) begin
          state_d = HOLD;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        byte_vld = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = HOLD;
    endcase
  end

  // Read data is only consumed while byte_vld is high (the CAPTURE cycle).
  assign byte_data = fifo_data;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// UART Rx frame parser: pops bytes from the Rx FIFO, hunts for start-of-frame, checks the
// LEN field and the 8-bit checksum, and streams payload bytes on a valid/ready interface.
// Frame: SOF, LEN, payload[LEN], CKS; good when (LEN + sum(payload) + CKS) mod 256 == 0.
// Optional feature: define UART_PARSER_TIMEOUT_EN to build the inter-byte timeout, which
// aborts a frame with err_code 3 after tmo_cyc cycles spent waiting on an empty FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   fifo_empty   Rx FIFO empty flag
//   fifo_rd      Rx FIFO pop strobe
//   fifo_data    Rx FIFO read data
//   m_data       payload byte, m_valid/m_ready handshake, m_last on final byte
//   frame_ok     1-cycle pulse, checksum correct
//   frame_err    1-cycle pulse, frame rejected
//   err_code     0 none, 1 bad LEN, 2 bad checksum, 3 timeout; held until next result
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned     dbit    = 8,
  parameter int unsigned     max_len = 64,
  parameter logic [dbit-1:0] sof     = SOF_DEFAULT,
  parameter int unsigned     tmo_cyc = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  output logic            fifo_rd,
  input  logic [dbit-1:0] fifo_data,
  output logic [dbit-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [1:0]      err_code
);

  localparam logic [dbit-1:0] MaxLen = dbit'(max_len);

  phase_e          phase_q, phase_d;
  logic [dbit-1:0] cnt_q, cnt_d;
  logic [dbit-1:0] sum_q, sum_d;
  logic [dbit-1:0] m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  logic            req;
  logic [dbit-1:0] byte_data;
  logic            byte_vld;

  // No pop while a payload byte is waiting for m_ready.
  assign req = !m_valid_q;

  uart_fifo_fetch #(
    .dbit(dbit)
  ) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .byte_data (byte_data),
    .byte_vld  (byte_vld)
  );

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = (tmo_cyc > 1) ? $clog2(tmo_cyc) : 1;

  logic [TmoW-1:0] tmo_q;
  logic            tmo_run;
  logic            tmo_hit;

  // Counts only while mid-frame and starved by the FIFO; m_ready stalls drop req.
  assign tmo_run = (phase_q != HUNT) && req && fifo_empty && !byte_vld;
  assign tmo_hit = tmo_run && (tmo_q == TmoW'(tmo_cyc - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (byte_vld || phase_q == HUNT || tmo_hit) begin
      tmo_q <= '0;
    end else if (tmo_run) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= HUNT;
      cnt_q     <= '0;
      sum_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;

    // Payload accept; byte_vld cannot coincide because req is low while m_valid is high.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      sum_d     = add8(sum_q, m_data_q);
      cnt_d     = cnt_q - 1'b1;
      if (cnt_q == dbit'(1)) phase_d = CKS;
    end

    if (byte_vld) begin
      unique case (phase_q)
        HUNT: begin
          if (byte_data == sof) phase_d = LEN;
        end
        LEN: begin
          if (byte_data == '0 || byte_data > MaxLen) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            phase_d = HUNT;
          end else begin
            cnt_d   = byte_data;
            sum_d   = byte_data;
            phase_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          m_data_d  = byte_data;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == dbit'(1));
        end
        CKS: begin
          if (add8(sum_q, byte_data) == 8'd0) begin
            ok_d   = 1'b1;
            code_d = ERR_NONE;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CKS;
          end
          phase_d = HUNT;
        end
        default: phase_d = HUNT;
      endcase
    end

`ifdef UART_PARSER_TIMEOUT_EN
    if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      phase_d = HUNT;
    end
`endif
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

endmodule
